hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Pipeline hazard and stall controller for the 24-bit pipelined core.
- Consumes the register tags and control bits that the Decode/Execute, Execute/Memory and Memory/Writeback pipeline registers emit.
- Drives the forwarding selects, plus the stall and clear (flush) inputs of those pipeline registers.
- Adds a data-memory wait handshake with timeout, and saturating stall/flush performance counters.

Parameters:
- R, 4, register-address width
- MEM_TIMEOUT, 15, max consecutive memory-wait cycles before error
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- RA1D, RA2D  in  R  source register tags in Decode
- RA1E, RA2E  in  R  source register tags in Execute
- A3E, A3M, A3W  in  R  destination tags in Execute/Memory/Writeback
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage
- MemtoRegE  in  1  Execute instruction is a load
- BranchTakenE  in  1  branch resolved taken in Execute
- mem_req  in  1  Memory-stage access active
- mem_ready  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  clear stage register (drive clr)
- mem_err  out  1  sticky memory timeout flag
- stall_cycles  out  CNT_W  cycles with StallF=1
- flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- Reset:
  - When rst=0 at a rising edge: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0.
  - While rst=0, combinational outputs are forced: Forward*=00, all Stall*=0, FlushD=FlushE=FlushW=1.
  - Reset mid-wait or in MEM_ERR returns to RUN in one edge.
- Forwarding (combinational, independent of state):
  - ForwardAE=10 if RegWriteM and A3M==RA1E.
  - Else 01 if RegWriteW and A3W==RA1E.
  - Else 00.
  - Memory stage has priority over Writeback. ForwardBE is the same, using RA2E.
- Hazard terms (combinational):
  - ldstall = MemtoRegE & RegWriteE & (RA1D==A3E | RA2D==A3E)
  - memstall = mem_req & ~mem_ready
- FSM states:
  - RUN (00): memstall -> MEM_WAIT with wait_cnt=1; else stay.
  - MEM_WAIT (01): mem_ready -> RUN with wait_cnt=0; else if wait_cnt==MEM_TIMEOUT -> MEM_ERR and mem_err<=1; else wait_cnt+1.
  - MEM_ERR (10): absorbing until reset; mem_err=1.
- Output priority (highest first):
  1. MEM_ERR: StallF/D/E/M=1, FlushW=1, no other flush.
  2. memstall (RUN or MEM_WAIT): StallF/D/E/M=1, FlushW=1. Branch and load-use effects are suppressed, and flush_count does not increment.
  3. BranchTakenE: FlushD=FlushE=1, no stalls. A wrong-path load-use is ignored.
  4. ldstall: StallF=StallD=1, FlushE=1.
  5. Otherwise all Stall*/Flush* are 0.
- mem_ready timing: the cycle mem_ready=1 is seen, stalls deassert combinationally in that same cycle. Zero-wait access (mem_req & mem_ready) never stalls.
- Counters:
  - stall_cycles increments on each edge where StallF=1 and rst=1.
  - flush_count increments on each edge where the BranchTakenE flush is actually asserted.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Width rules: tag compares are full R bits; register 0 is not special.

Test Plan:
- Forwarding: RA1E=3, A3M=3, RegWriteM=1, A3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. RA2E=5 with no match -> ForwardBE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, A3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for exactly one cycle; stall_cycles goes 0->1.
- Branch vs load-use: BranchTakenE=1 and ldstall=1 in the same cycle -> FlushD=FlushE=1, StallF=0, flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> Stall*=1 and FlushW=1 for those 3 cycles; the state returns to RUN (00) after the mem_ready cycle; stall_cycles=3.
- Timeout: mem_req=1, mem_ready=0 held for 16 cycles -> mem_err=1 after wait_cnt reaches 15, stalls persist. rst=0 for one edge -> mem_err=0, state RUN, counters 0.
- Saturation: with CNT_W=4, hold the load-use stall for 20 cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_control_if.sv
// Hazard controller bundle: pipeline tags/control in, forwarding/stall/flush out.
// The pipeline side uses master, the controller uses slave.
interface hazard_control_if #(
    parameter int R     = 4,
    parameter int CNT_W = 16
);
    logic [R-1:0]     RA1D;
    logic [R-1:0]     RA2D;
    logic [R-1:0]     RA1E;
    logic [R-1:0]     RA2E;
    logic [R-1:0]     A3E;
    logic [R-1:0]     A3M;
    logic [R-1:0]     A3W;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             BranchTakenE;
    logic             mem_req;
    logic             mem_ready;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, BranchTakenE, mem_req, mem_ready,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, BranchTakenE, mem_req, mem_ready,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output mem_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard controller: operand forwarding, load-use and branch
// handling, data-memory wait with timeout, saturating stall/flush counters.
module hazard_control #(
    parameter int R           = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_control_if.slave hc
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT = WC_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic       ldstall;
    logic       memstall;
    logic       br_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d_o, stall_e, stall_m;
    logic       flush_d_o, flush_e, flush_w;

    // Memory stage result is newer than writeback, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [R-1:0] ra,
        input logic [R-1:0] a3m,
        input logic         wem,
        input logic [R-1:0] a3w,
        input logic         wew
    );
        if (wem && (a3m == ra)) return 2'b10;
        if (wew && (a3w == ra)) return 2'b01;
        return 2'b00;
    endfunction

    assign ldstall = hc.MemtoRegE & hc.RegWriteE &
                     ((hc.RA1D == hc.A3E) | (hc.RA2D == hc.A3E));
    assign memstall = hc.mem_req & ~hc.mem_ready;

    assign fwd_a = fwd_sel(hc.RA1E, hc.A3M, hc.RegWriteM,
                           hc.A3W, hc.RegWriteW);
    assign fwd_b = fwd_sel(hc.RA2E, hc.A3M, hc.RegWriteM,
                           hc.A3W, hc.RegWriteW);

    // Prioritised stall/flush decode; reset forces all pipeline regs clear.
    always_comb begin
        hc.ForwardAE = 2'b00;
        hc.ForwardBE = 2'b00;
        stall_f      = 1'b0;
        stall_d_o    = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d_o    = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        br_flush     = 1'b0;
        if (!rst) begin
            flush_d_o = 1'b1;
            flush_e   = 1'b1;
            flush_w   = 1'b1;
        end else begin
            hc.ForwardAE = fwd_a;
            hc.ForwardBE = fwd_b;
            if ((state_q == MEM_ERR) || memstall) begin
                stall_f   = 1'b1;
                stall_d_o = 1'b1;
                stall_e   = 1'b1;
                stall_m   = 1'b1;
                flush_w   = 1'b1;
            end else if (hc.BranchTakenE) begin
                flush_d_o = 1'b1;
                flush_e   = 1'b1;
                br_flush  = 1'b1;
            end else if (ldstall) begin
                stall_f   = 1'b1;
                stall_d_o = 1'b1;
                flush_e   = 1'b1;
            end
        end
    end

    assign hc.StallF = stall_f;
    assign hc.StallD = stall_d_o;
    assign hc.StallE = stall_e;
    assign hc.StallM = stall_m;
    assign hc.FlushD = flush_d_o;
    assign hc.FlushE = flush_e;
    assign hc.FlushW = flush_w;

    // Memory wait tracking and saturating performance counters.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        stall_d = stall_q;
        flush_d = flush_q;
        unique case (state_q)
            RUN: begin
                if (memstall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hc.mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT) begin
                    state_d = MEM_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            MEM_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        if (stall_f && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (br_flush && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hc.mem_err      = err_q;
    assign hc.stall_cycles = stall_q;
    assign hc.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed scenarios plus randomized cycles
// compared against a behavioural model of the hazard rules.
module tb_hazard_control;
    localparam int R  = 4;
    localparam int MT = 15;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    hazard_control_if #(.R(R), .CNT_W(CW)) bus ();

    hazard_control #(.R(R), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [10:0] act_ctl;
    assign act_ctl = {bus.ForwardAE, bus.ForwardBE,
                      bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                      bus.FlushD, bus.FlushE, bus.FlushW};

    // Model state: sticky error, length of current memory-wait episode,
    // and the two event counts.
    bit m_err;
    int m_ep;
    int m_stall;
    int m_flush;

    function automatic logic [1:0] m_fwd(input logic [R-1:0] ra);
        if (bus.RegWriteM && bus.A3M == ra) return 2'd2;
        if (bus.RegWriteW && bus.A3W == ra) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [10:0] exp_ctl();
        logic ld, ms;
        logic [6:0] sf;
        if (!rst) return 11'b00_00_0000_111;
        ld = bus.MemtoRegE && bus.RegWriteE &&
             (bus.RA1D == bus.A3E || bus.RA2D == bus.A3E);
        ms = bus.mem_req && !bus.mem_ready;
        if (m_err || ms)           sf = 7'b1111_001;
        else if (bus.BranchTakenE) sf = 7'b0000_110;
        else if (ld)               sf = 7'b1100_010;
        else                       sf = 7'b0000_000;
        return {m_fwd(bus.RA1E), m_fwd(bus.RA2E), sf};
    endfunction

    task automatic model_advance();
        logic [10:0] c;
        c = exp_ctl();
        if (!rst) begin
            m_err = 0; m_ep = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[6] && m_stall < CMAX) m_stall++;
            if (c[2] && m_flush < CMAX) m_flush++;
            if (m_ep > 0) begin
                if (bus.mem_ready) m_ep = 0;
                else m_ep++;
            end else if (bus.mem_req && !bus.mem_ready) begin
                m_ep = 1;
            end
            if (m_ep > MT) m_err = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle();
        bus.RA1D = '0; bus.RA2D = '0; bus.RA1E = '0; bus.RA2E = '0;
        bus.A3E = '0; bus.A3M = '0; bus.A3W = '0;
        bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.MemtoRegE = 0; bus.BranchTakenE = 0;
        bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        bus.RA1E = 4'd3; bus.A3M = 4'd3; bus.RegWriteM = 1;
        bus.mem_req = 1;
        #2;
        checks++;
        if (act_ctl !== 11'b00_00_0000_111) begin
            errors++;
            $display("FAIL reset_forced ctl=%b exp=%b", act_ctl, 11'b00_00_0000_111);
        end
        tick();
        idle();
        #2;
        checks++;
        if ({bus.mem_err, bus.stall_cycles, bus.flush_count} !== '0) begin
            errors++;
            $display("FAIL reset_state err=%b stall=%0d flush=%0d exp 0",
                     bus.mem_err, bus.stall_cycles, bus.flush_count);
        end
        rst = 1;
    endtask

    task automatic test_forwarding();
        do_reset();
        bus.RA1E = 4'd3; bus.A3M = 4'd3; bus.RegWriteM = 1;
        bus.A3W = 4'd3; bus.RegWriteW = 1; bus.RA2E = 4'd5;
        #2;
        checks++;
        if (bus.ForwardAE !== 2'b10 || bus.ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_mem A=%b B=%b exp 10 00", bus.ForwardAE, bus.ForwardBE);
        end
        bus.RegWriteM = 0;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_wb A=%b exp 01", bus.ForwardAE);
        end
        bus.RA1E = 4'hF; bus.A3M = 4'h7; bus.RegWriteM = 1;
        bus.A3W = 4'h5; bus.RegWriteW = 1;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b00 || bus.ForwardBE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_fullwidth A=%b B=%b exp 00 01", bus.ForwardAE, bus.ForwardBE);
        end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.A3E = 4'd2;
        bus.RA2D = 4'd2; bus.RA1D = 4'd7;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b1100_010) begin
            errors++;
            $display("FAIL load_use ctl=%b exp 1100010", act_ctl[6:0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b0 || bus.stall_cycles !== 4'd1) begin
            errors++;
            $display("FAIL load_use_after ctl=%b stall=%0d exp 0 1",
                     act_ctl[6:0], bus.stall_cycles);
        end
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.A3E = 4'd2;
        bus.RA1D = 4'd2; bus.BranchTakenE = 1;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b0000_110) begin
            errors++;
            $display("FAIL branch_over_ld ctl=%b exp 0000110", act_ctl[6:0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (bus.flush_count !== 4'd1 || bus.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL branch_count flush=%0d stall=%0d exp 1 0",
                     bus.flush_count, bus.stall_cycles);
        end
        bus.BranchTakenE = 1; bus.mem_req = 1; bus.mem_ready = 0;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b1111_001) begin
            errors++;
            $display("FAIL memstall_over_branch ctl=%b exp 1111001", act_ctl[6:0]);
        end
        tick();
        bus.BranchTakenE = 0; bus.mem_ready = 1;
        #2;
        checks++;
        if (bus.flush_count !== 4'd1) begin
            errors++;
            $display("FAIL branch_suppressed flush=%0d exp 1", bus.flush_count);
        end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 1;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b0) begin
            errors++;
            $display("FAIL zero_wait ctl=%b exp 0", act_ctl[6:0]);
        end
        tick();
        bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (act_ctl[6:0] !== 7'b1111_001) begin
                errors++;
                $display("FAIL mem_wait_%0d ctl=%b exp 1111001", i, act_ctl[6:0]);
            end
            tick();
        end
        bus.mem_ready = 1;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b0) begin
            errors++;
            $display("FAIL mem_ready_release ctl=%b exp 0", act_ctl[6:0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (bus.stall_cycles !== 4'd3 || bus.mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_count stall=%0d err=%b exp 3 0",
                     bus.stall_cycles, bus.mem_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                checks++;
                if (bus.mem_err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early err=%b exp 0", bus.mem_err);
                end
            end
        end
        checks++;
        if (bus.mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err err=%b exp 1", bus.mem_err);
        end
        bus.mem_req = 0; bus.mem_ready = 1; bus.BranchTakenE = 1;
        #2;
        checks++;
        if (act_ctl[6:0] !== 7'b1111_001 || bus.stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL err_persist ctl=%b stall=%0d exp 1111001 15",
                     act_ctl[6:0], bus.stall_cycles);
        end
        rst = 0;
        tick();
        rst = 1;
        idle();
        #2;
        checks++;
        if (bus.mem_err !== 1'b0 || bus.stall_cycles !== 4'd0 ||
            bus.flush_count !== 4'd0 || act_ctl[6:0] !== 7'b0) begin
            errors++;
            $display("FAIL err_reset err=%b stall=%0d flush=%0d ctl=%b exp 0",
                     bus.mem_err, bus.stall_cycles, bus.flush_count, act_ctl[6:0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.A3E = 4'd9; bus.RA1D = 4'd9;
        for (int i = 0; i < 20; i++) tick();
        #2;
        checks++;
        if (bus.stall_cycles !== 4'd15 || bus.StallF !== 1'b1) begin
            errors++;
            $display("FAIL saturation stall=%0d StallF=%b exp 15 1",
                     bus.stall_cycles, bus.StallF);
        end
        idle();
    endtask

    task automatic test_random();
        logic [10:0] e;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            bus.RA1D = R'($urandom_range(0, 3));
            bus.RA2D = R'($urandom_range(0, 3));
            bus.RA1E = R'($urandom_range(0, 3));
            bus.RA2E = R'($urandom_range(0, 3));
            bus.A3E = R'($urandom_range(0, 3));
            bus.A3M = R'($urandom_range(0, 3));
            bus.A3W = R'($urandom_range(0, 3));
            bus.RegWriteE = 1'($urandom);
            bus.RegWriteM = 1'($urandom);
            bus.RegWriteW = 1'($urandom);
            bus.MemtoRegE = 1'($urandom);
            bus.BranchTakenE = ($urandom_range(0, 3) == 0);
            bus.mem_req = ($urandom_range(0, 2) == 0);
            bus.mem_ready = ($urandom_range(0, 4) != 0);
            #2;
            e = exp_ctl();
            checks++;
            if (act_ctl !== e) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d ctl=%b exp=%b", n, act_ctl, e);
            end
            checks++;
            if (bus.mem_err !== m_err || bus.stall_cycles !== CW'(m_stall) ||
                bus.flush_count !== CW'(m_flush)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d err=%b stall=%0d flush=%0d exp %b %0d %0d",
                         n, bus.mem_err, bus.stall_cycles, bus.flush_count,
                         m_err, m_stall, m_flush);
            end
            tick();
        end
        rst = 1;
        idle();
    endtask

    initial begin
        m_err = 0; m_ep = 0; m_stall = 0; m_flush = 0;
        idle();
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
